axil_regbank_arbiter: RTL and testbench
=======================================

// Module: axil_regbank_arbiter
// PURPOSE
//  Shares one single-ported register bank between the AXI4-Lite read and write channels.
//  Accepts one transaction at a time: a read address, or a write address together with
//  its write data. Issues a single bank access, then holds the R or B response until the
//  master takes it. Round-robin arbitration applies when a read and a write arrive together.
//  Sits between the AXI4-Lite slave port and the register bank / decode logic.
// PARAMETERS
//  C_ADDR_WIDTH  8   AXI byte-address width; bank word index = addr[C_ADDR_WIDTH-1:2]
//  C_DATA_WIDTH  32  data width; must be 32 (wstrb is C_DATA_WIDTH/8 bits)
// PORTS
//  clk        in   1     single clock, all logic on rising edge
//  reset      in   1     asynchronous, active-high reset
//  araddr     in   AW    read address
//  arvalid    in   1     read address valid
//  arready    out  1     read address accepted (when high together with arvalid)
//  rdata      out  DW    registered read data
//  rresp      out  2     always 2'b00 (OKAY)
//  rvalid     out  1     read response valid
//  rready     in   1     master accepts read response
//  awaddr     in   AW    write address
//  awvalid    in   1     write address valid
//  awready    out  1     write address accepted
//  wdata      in   DW    write data
//  wstrb      in   DW/8  write byte strobes
//  wvalid     in   1     write data valid
//  wready     out  1     write data accepted (always equal to awready)
//  bresp      out  2     always 2'b00 (OKAY)
//  bvalid     out  1     write response valid
//  bready     in   1     master accepts write response
//  reg_addr   out  AW-2  bank word index, registered
//  reg_wdata  out  DW    bank write data, registered
//  reg_wstrb  out  DW/8  bank byte enables, registered
//  reg_we     out  1     one-cycle bank write strobe
//  reg_re     out  1     one-cycle bank read strobe
//  reg_rdata  in   DW    bank read data; valid exactly 1 cycle after reg_re
// BEHAVIOUR
//  States: IDLE, RD_ISSUE, RD_CAPT, RD_RESP, WR_ISSUE, WR_RESP.
//  IDLE:
//   - rd_req = arvalid; wr_req = awvalid & wvalid. AW without W, or W without AW, is not accepted.
//   - Grant to read if rd_req & (~wr_req | last_was_wr).
//   - Grant to write if wr_req & (~rd_req | ~last_was_wr).
//   - arready = IDLE & rd grant; awready = wready = IDLE & wr grant. Combinational on valids.
//  Read grant: latch araddr, set last_was_wr=0, go to RD_ISSUE.
//  RD_ISSUE: reg_re=1, then RD_CAPT.
//  RD_CAPT: rdata <= reg_rdata, then RD_RESP.
//  RD_RESP: rvalid=1, rdata held stable; on rready go to IDLE.
//  Write grant: latch awaddr, wdata and wstrb; set last_was_wr=1; go to WR_ISSUE.
//  WR_ISSUE: reg_we=1, then WR_RESP.
//  WR_RESP: bvalid=1; on bready go to IDLE.
//  Latency (accept edge = T): reg_re/reg_we high in cycle T+1.
//   - rvalid first high at T+3; bvalid first high at T+2.
//   - A new accept is possible in the cycle after the response handshake.
//  Address bits [1:0] are ignored. No address decode or error response; resp is always OKAY.
//  reg_* outputs keep their last values outside strobe cycles; the bank qualifies them by the strobes.
//  Async reset:
//   - state=IDLE, last_was_wr=1 (so the first collision grants read).
//   - All outputs 0, including rdata, reg_addr, reg_wdata and reg_wstrb.
//   - Reset in any state abandons the transaction: no response is issued, and no strobe fires
//     after reset deasserts.
//  A valid that drops before being accepted is legal and is simply not served.
// TESTING
//  1 Reset release, idle bus -> all outputs 0; arready=awready=0 until a valid is seen.
//  2 Read @0x04, bank returns 0xDEADBEEF, rready=1 -> reg_re at T+1 with reg_addr=1;
//    rvalid/rdata=0xDEADBEEF at T+3; one beat only.
//  3 Write @0x08, wdata=0x12345678, wstrb=4'b0101, bready=1 -> reg_we at T+1
//    (addr=2, data/strb match); bvalid at T+2.
//  4 arvalid and awvalid&wvalid held together for 4 transactions -> grants alternate R,W,R,W.
//  5 awvalid=1, wvalid=0 for 5 cycles, then wvalid=1 -> awready stays 0 until wvalid;
//    then one write.
//  6 rready=0 for 10 cycles in RD_RESP, then reset -> rvalid held with stable rdata;
//    after reset: IDLE, rvalid=0, no reg strobes.

Source files
------------

// File: rtl/axil_regbank_arbiter_if.sv
// AXI4-Lite slave channels plus the register-bank side of axil_regbank_arbiter.
// The slave modport is the arbiter's view; master is the bus master / bank view.
interface axil_regbank_arbiter_if #(
  parameter int C_ADDR_WIDTH = 8,
  parameter int C_DATA_WIDTH = 32
);
  logic [C_ADDR_WIDTH-1:0]   araddr;
  logic                      arvalid;
  logic                      arready;
  logic [C_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;
  logic [C_ADDR_WIDTH-1:0]   awaddr;
  logic                      awvalid;
  logic                      awready;
  logic [C_DATA_WIDTH-1:0]   wdata;
  logic [C_DATA_WIDTH/8-1:0] wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [C_ADDR_WIDTH-3:0]   reg_addr;
  logic [C_DATA_WIDTH-1:0]   reg_wdata;
  logic [C_DATA_WIDTH/8-1:0] reg_wstrb;
  logic                      reg_we;
  logic                      reg_re;
  logic [C_DATA_WIDTH-1:0]   reg_rdata;

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready, reg_rdata,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
           reg_addr, reg_wdata, reg_wstrb, reg_we, reg_re
  );

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready, reg_rdata,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid,
           reg_addr, reg_wdata, reg_wstrb, reg_we, reg_re
  );
endinterface

// File: rtl/axil_regbank_arbiter.sv
// Serialises AXI4-Lite reads and writes onto one single-ported register bank,
// one transaction at a time, with round-robin choice when both arrive together.
module axil_regbank_arbiter #(
  parameter int C_ADDR_WIDTH = 8,
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  axil_regbank_arbiter_if.slave bus
);
  localparam int AW = C_ADDR_WIDTH;
  localparam int DW = C_DATA_WIDTH;
  localparam int SW = C_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_CAPT, RD_RESP, WR_ISSUE, WR_RESP
  } state_t;

  state_t          state_q, state_d;
  logic            last_wr_q, last_wr_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [AW-3:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            rd_req, wr_req, rd_gnt, wr_gnt;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^{bus.araddr[1:0], bus.awaddr[1:0]};

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rd_req    = bus.arvalid;
    wr_req    = bus.awvalid & bus.wvalid;
    rd_gnt    = 1'b0;
    wr_gnt    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // last_wr_q breaks the tie when both channels request in the same cycle
        rd_gnt = rd_req & (~wr_req | last_wr_q);
        wr_gnt = wr_req & (~rd_req | ~last_wr_q);
        if (rd_gnt) begin
          addr_d    = bus.araddr[AW-1:2];
          last_wr_d = 1'b0;
          state_d   = RD_ISSUE;
        end else if (wr_gnt) begin
          addr_d    = bus.awaddr[AW-1:2];
          wdata_d   = bus.wdata;
          wstrb_d   = bus.wstrb;
          last_wr_d = 1'b1;
          state_d   = WR_ISSUE;
        end
      end
      RD_ISSUE: state_d = RD_CAPT;
      RD_CAPT: begin
        rdata_d = bus.reg_rdata;
        state_d = RD_RESP;
      end
      RD_RESP:  if (bus.rready) state_d = IDLE;
      WR_ISSUE: state_d = WR_RESP;
      WR_RESP:  if (bus.bready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b1;
      rdata_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign bus.arready   = rd_gnt;
  assign bus.awready   = wr_gnt;
  assign bus.wready    = wr_gnt;
  assign bus.rdata     = rdata_q;
  assign bus.rresp     = 2'b00;
  assign bus.rvalid    = (state_q == RD_RESP);
  assign bus.bresp     = 2'b00;
  assign bus.bvalid    = (state_q == WR_RESP);
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_wstrb = wstrb_q;
  assign bus.reg_re    = (state_q == RD_ISSUE);
  assign bus.reg_we    = (state_q == WR_ISSUE);
endmodule

// File: tb/tb_axil_regbank_arbiter.sv
// Bench for axil_regbank_arbiter: vector table of reads/writes against a small bank
// model, scoreboarded R/B responses, and hand-written collision/stall/reset sequences.
module tb_axil_regbank_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axil_regbank_arbiter_if #(.C_ADDR_WIDTH(8), .C_DATA_WIDTH(32)) bus ();

  axil_regbank_arbiter #(.C_ADDR_WIDTH(8), .C_DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    bit          is_wr;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];
  exp_t e_mon;

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Register bank: registered read data one cycle after reg_re, byte-strobed writes
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hFFFF_FFFF;
      mem[1] <= 32'hDEAD_BEEF;
    end else begin
      if (bus.reg_re) bus.reg_rdata <= mem[bus.reg_addr];
      if (bus.reg_we)
        for (int b = 0; b < 4; b++)
          if (bus.reg_wstrb[b]) mem[bus.reg_addr][8*b +: 8] <= bus.reg_wdata[8*b +: 8];
    end
  end

  // Response monitor: a handshake completes at the next rising edge
  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      if (bus.rvalid && bus.rready) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_unexpected_r: got rdata %0h expected no response", bus.rdata);
        end else begin
          e_mon = sb_q.pop_front();
          chk("sb_r_kind", {63'b0, e_mon.is_wr}, 64'd0);
          chk("sb_rdata", {32'b0, bus.rdata}, {32'b0, e_mon.data});
          chk("sb_rresp", {62'b0, bus.rresp}, 64'd0);
        end
      end
      if (bus.bvalid && bus.bready) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_unexpected_b: got bvalid 1 expected no response");
        end else begin
          e_mon = sb_q.pop_front();
          chk("sb_b_kind", {63'b0, e_mon.is_wr}, 64'd1);
          chk("sb_bresp", {62'b0, bus.bresp}, 64'd0);
        end
      end
    end
  end

  task automatic wait_accept(input bit is_wr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (is_wr ? bus.awready : bus.arready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL accept_timeout: got no ready expected ready within 20 cycles");
    end
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] exp_d);
    bit ok;
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    wait_accept(1'b0, ok);
    if (!ok) begin
      bus.arvalid = 1'b0;
      return;
    end
    sb_q.push_back('{1'b0, exp_d});
    @(negedge clk);
    bus.arvalid = 1'b0;
    #1;
    chk("rd_reg_re_t1", {63'b0, bus.reg_re}, 64'd1);
    chk("rd_reg_addr", {58'b0, bus.reg_addr}, {58'b0, a[7:2]});
    chk("rd_reg_we_t1", {63'b0, bus.reg_we}, 64'd0);
    @(negedge clk);
    #1;
    chk("rd_rvalid_t2", {63'b0, bus.rvalid}, 64'd0);
    chk("rd_reg_re_t2", {63'b0, bus.reg_re}, 64'd0);
    @(negedge clk);
    #1;
    chk("rd_rvalid_t3", {63'b0, bus.rvalid}, 64'd1);
    @(negedge clk);
    #1;
    chk("rd_one_beat", {63'b0, bus.rvalid}, 64'd0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    bit ok;
    bus.awaddr  = a;
    bus.wdata   = d;
    bus.wstrb   = s;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    wait_accept(1'b1, ok);
    if (!ok) begin
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      return;
    end
    chk("wr_wready_eq", {63'b0, bus.wready}, 64'd1);
    sb_q.push_back('{1'b1, 32'h0});
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    #1;
    chk("wr_reg_we_t1", {63'b0, bus.reg_we}, 64'd1);
    chk("wr_reg_addr", {58'b0, bus.reg_addr}, {58'b0, a[7:2]});
    chk("wr_reg_wdata", {32'b0, bus.reg_wdata}, {32'b0, d});
    chk("wr_reg_wstrb", {60'b0, bus.reg_wstrb}, {60'b0, s});
    chk("wr_bvalid_t1", {63'b0, bus.bvalid}, 64'd0);
    @(negedge clk);
    #1;
    chk("wr_bvalid_t2", {63'b0, bus.bvalid}, 64'd1);
    chk("wr_reg_we_t2", {63'b0, bus.reg_we}, 64'd0);
    @(negedge clk);
    #1;
    chk("wr_one_beat", {63'b0, bus.bvalid}, 64'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_arready"}, {63'b0, bus.arready}, 64'd0);
    chk({tag, "_awready"}, {62'b0, bus.awready, bus.wready}, 64'd0);
    chk({tag, "_valids"}, {62'b0, bus.rvalid, bus.bvalid}, 64'd0);
    chk({tag, "_strobes"}, {62'b0, bus.reg_re, bus.reg_we}, 64'd0);
    chk({tag, "_rdata"}, {32'b0, bus.rdata}, 64'd0);
    chk({tag, "_reg_bus"}, {22'b0, bus.reg_addr, bus.reg_wdata, bus.reg_wstrb}, 64'd0);
  endtask

  bit exp_wr[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int g;
    vecs[0] = '{1'b0, 8'h04, 32'h0,         4'h0,    32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 8'h08, 32'h1234_5678, 4'b0101, 32'h0};
    vecs[2] = '{1'b0, 8'h08, 32'h0,         4'h0,    32'hFF34_FF78};
    vecs[3] = '{1'b1, 8'h0B, 32'hAABB_CCDD, 4'b1010, 32'h0};
    vecs[4] = '{1'b0, 8'h0A, 32'h0,         4'h0,    32'hAA34_CC78};
    vecs[5] = '{1'b1, 8'hFC, 32'h0000_0000, 4'b1111, 32'h0};
    vecs[6] = '{1'b0, 8'hFE, 32'h0,         4'h0,    32'h0000_0000};
    vecs[7] = '{1'b0, 8'h00, 32'h0,         4'h0,    32'hFFFF_FFFF};

    reset = 1'b1;
    bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b1; bus.reg_rdata = '0;

    repeat (2) @(negedge clk);
    #1;
    chk_idle_outputs("rst_hold");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk_idle_outputs("rst_idle");
    end

    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
      else               do_read(vecs[i].addr, vecs[i].exp_rdata);
    end

    // Collision: after reset the first simultaneous request must go to the read side
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.araddr = 8'h04; bus.arvalid = 1'b1;
    bus.awaddr = 8'h10; bus.wdata = 32'h55; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    g = 0;
    for (int cyc = 0; cyc < 60 && g < 4; cyc++) begin
      #1;
      if (bus.arready || bus.awready) begin
        chk("coll_grant_is_wr", {63'b0, bus.awready}, {63'b0, exp_wr[g]});
        chk("coll_exclusive", {63'b0, bus.arready & bus.awready}, 64'd0);
        if (bus.awready) sb_q.push_back('{1'b1, 32'h0});
        else             sb_q.push_back('{1'b0, 32'hDEAD_BEEF});
        g++;
      end
      @(negedge clk);
    end
    bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    if (g < 4) begin
      n_chk++;
      $display("FAIL coll_timeout: got %0d grants expected 4", g);
    end
    repeat (6) @(negedge clk);

    // Address without data must wait for wvalid
    bus.awaddr = 8'h20; bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("aw_only_awready", {62'b0, bus.awready, bus.wready}, 64'd0);
      @(negedge clk);
    end
    do_write(8'h20, 32'hCAFE_F00D, 4'hF);
    do_read(8'h20, 32'hCAFE_F00D);

    // Stalled read response, then reset abandons it
    bus.rready  = 1'b0;
    bus.araddr  = 8'h04;
    bus.arvalid = 1'b1;
    begin
      bit ok;
      wait_accept(1'b0, ok);
      if (ok) begin
        @(negedge clk);
        bus.arvalid = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
          #1;
          chk("stall_rvalid", {63'b0, bus.rvalid}, 64'd1);
          chk("stall_rdata", {32'b0, bus.rdata}, {32'b0, 32'hDEAD_BEEF});
          @(negedge clk);
        end
      end
      bus.arvalid = 1'b0;
    end
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_rvalid", {63'b0, bus.rvalid}, 64'd0);
    chk("async_rst_rdata", {32'b0, bus.rdata}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.rready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk_idle_outputs("post_rst");
    end

    chk("sb_drained", {32'b0, sb_q.size()}, 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end
endmodule
